// File: rtl/divider_pkg.sv
// Shared types and helpers for the multi-channel clock-enable divider.
package divider_pkg;

  localparam int MAX_DIV_W   = 32;
  localparam int DEFAULT_DIV = 4;

  typedef logic [MAX_DIV_W-1:0] div_t;
  typedef logic [3:0]           chan_t;

  // High time of one period; odd divisors spend the extra cycle high.
  function automatic div_t half_period(input div_t d);
    logic [MAX_DIV_W:0] sum;
    sum = {1'b0, d} + (MAX_DIV_W+1)'(1);
    return div_t'(sum >> 1);
  endfunction

endpackage

// File: rtl/divider_channel.sv
// One divider channel: counter, active divisor and a single pending divisor slot.
// With DIVIDER_SYNC_EN defined, sync_i restarts the counter and applies any pending divisor.
module divider_channel
  import divider_pkg::*;
#(
  parameter int DIV_W     = 16,
  parameter int RESET_DIV = DEFAULT_DIV
) (
  input  logic             clk,
  input  logic             rst,
`ifdef DIVIDER_SYNC_EN
  input  logic             sync_i,
`endif
  input  logic             wr_en_i,
  input  logic [DIV_W-1:0] wr_div_i,
  output logic             tick_o,
  output logic             level_o,
  output logic             active_o,
  output logic             busy_o
);

  localparam logic [DIV_W-1:0] RESET_VAL = DIV_W'(RESET_DIV);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic             pend_vld_q, pend_vld_d;
  logic [DIV_W-1:0] half;
  logic             enabled;
  logic             wrap;
  logic             apply;

  assign enabled = (div_q != '0);
  assign wrap    = enabled && (cnt_q == div_q - DIV_W'(1));
  assign half    = DIV_W'(half_period(div_t'(div_q)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      div_q      <= RESET_VAL;
      pend_div_q <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_div_q <= pend_div_d;
      pend_vld_q <= pend_vld_d;
    end
  end

  // A pending divisor lands only at a period boundary (or immediately when idle),
  // so the running period always completes.
  always_comb begin
    cnt_d      = cnt_q;
    div_d      = div_q;
    pend_div_d = pend_div_q;
    pend_vld_d = pend_vld_q;
    apply      = 1'b0;
`ifdef DIVIDER_SYNC_EN
    if (sync_i) begin
      cnt_d = '0;
      apply = pend_vld_q;
    end else
`endif
    if (!enabled || wrap) begin
      cnt_d = '0;
      apply = pend_vld_q;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
    if (apply) begin
      div_d      = pend_div_q;
      pend_vld_d = 1'b0;
    end
    if (wr_en_i) begin
      pend_div_d = wr_div_i;
      pend_vld_d = 1'b1;
    end
  end

  assign tick_o   = wrap;
  assign level_o  = enabled && (cnt_q < half);
  assign active_o = enabled;
  assign busy_o   = pend_vld_q;

endmodule

// File: rtl/multi_channel_divider.sv
// CHANNELS independent programmable clock-enable dividers behind one valid/ready config port.
// Defining DIVIDER_SYNC_EN adds sync_i, which phase-aligns every channel.
module multi_channel_divider #(
  parameter int CHANNELS    = 4,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = divider_pkg::DEFAULT_DIV,
  localparam int CHAN_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
`ifdef DIVIDER_SYNC_EN
  input  logic                sync_i,
`endif
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CHAN_W-1:0]   cfg_chan,
  input  logic [DIV_W-1:0]    cfg_div,
  output logic [CHANNELS-1:0] tick_o,
  output logic [CHANNELS-1:0] level_o,
  output logic [CHANNELS-1:0] active_o
);

  // Handshake: a write transfers on any cycle with cfg_valid && cfg_ready; the
  // addressed channel is ready only while its pending slot is empty, and
  // out-of-range channel indices are always ready and silently dropped.
  logic [CHANNELS-1:0] busy;
  logic [CHANNELS-1:0] wr_en;

  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg_chan == CHAN_W'(i)) cfg_ready = !busy[i];
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    assign wr_en[g] = cfg_valid && cfg_ready && (cfg_chan == CHAN_W'(g));

    divider_channel #(
      .DIV_W     (DIV_W),
      .RESET_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
`ifdef DIVIDER_SYNC_EN
      .sync_i   (sync_i),
`endif
      .wr_en_i  (wr_en[g]),
      .wr_div_i (cfg_div),
      .tick_o   (tick_o[g]),
      .level_o  (level_o[g]),
      .active_o (active_o[g]),
      .busy_o   (busy[g])
    );
  end

endmodule

// File: tb/tb_multi_channel_divider.sv
// Bench for multi_channel_divider: arithmetic reference model checked every cycle plus directed literals.
module tb_multi_channel_divider;

  localparam int CH = 5;
  localparam int DW = 4;
  localparam int CW = 3;
  localparam int OW = 3 * CH;

  logic          clk;
  logic          rst;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] cfg_chan;
  logic [DW-1:0] cfg_div;
  logic [CH-1:0] tick_o;
  logic [CH-1:0] level_o;
  logic [CH-1:0] active_o;
`ifdef DIVIDER_SYNC_EN
  logic          sync_i;
`endif

  multi_channel_divider #(
    .CHANNELS    (CH),
    .DIV_W       (DW),
    .DEFAULT_DIV (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef DIVIDER_SYNC_EN
    .sync_i    (sync_i),
`endif
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_chan  (cfg_chan),
    .cfg_div   (cfg_div),
    .tick_o    (tick_o),
    .level_o   (level_o),
    .active_o  (active_o)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int ecnt    = 0;
  logic [OW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_div [CH];
  int m_pos [CH];
  int m_pend[CH];
  bit m_pvld[CH];

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_div[i]  = 4;
      m_pos[i]  = 0;
      m_pend[i] = 0;
      m_pvld[i] = 1'b0;
    end
  endtask

  function automatic bit model_ready(input int ch);
    if (ch >= CH) return 1'b1;
    return !m_pvld[ch];
  endfunction

  task automatic model_step(input logic v, input int ch, input int dv, input logic sy);
    bit acc;
    acc = v && model_ready(ch);
    for (int i = 0; i < CH; i++) begin
      bit at_end;
      at_end = (m_div[i] != 0) && (m_pos[i] == m_div[i] - 1);
      if (sy || m_div[i] == 0 || at_end) begin
        m_pos[i] = 0;
        if (m_pvld[i]) begin
          m_div[i]  = m_pend[i];
          m_pvld[i] = 1'b0;
        end
      end else begin
        m_pos[i] = m_pos[i] + 1;
      end
    end
    if (acc && ch < CH) begin
      m_pend[ch] = dv;
      m_pvld[ch] = 1'b1;
    end
  endtask

  function automatic logic [OW-1:0] model_outputs();
    logic [CH-1:0] t, l, a;
    for (int i = 0; i < CH; i++) begin
      a[i] = (m_div[i] != 0);
      t[i] = a[i] && (m_pos[i] == m_div[i] - 1);
      l[i] = a[i] && (m_pos[i] < (m_div[i] + 1) / 2);
    end
    return {t, l, a};
  endfunction

  // Inputs are captured mid-low-phase, the model advances on the edge, outputs are compared 1 ns later.
  initial begin : monitor
    logic c_rst, c_valid, c_sync;
    int   c_chan, c_div;
    model_reset();
    forever begin
      @(negedge clk);
      #2;
      c_rst   = rst;
      c_valid = cfg_valid;
      c_chan  = int'(cfg_chan);
      c_div   = int'(cfg_div);
      c_sync  = 1'b0;
`ifdef DIVIDER_SYNC_EN
      c_sync  = sync_i;
`endif
      if (!c_rst) begin
        model_reset();
        ecnt = 0;
      end else begin
        chk("cfg_ready", 32'(cfg_ready), 32'(model_ready(c_chan)));
      end
      @(posedge clk);
      if (c_rst) begin
        model_step(c_valid, c_chan, c_div, c_sync);
        ecnt++;
      end
      exp_q.push_back(model_outputs());
      #1;
      chk("tick_level_active", 32'({tick_o, level_o, active_o}), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_edge(input int n);
    while (ecnt < n) @(negedge clk);
  endtask

  task automatic cfg_write(input int ch, input int dv, output int waited);
    waited    = 0;
    cfg_valid = 1'b1;
    cfg_chan  = CW'(ch);
    cfg_div   = DW'(dv);
    #1;
    while (!cfg_ready && waited < 64) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!cfg_ready) chk("cfg_write_timeout", 32'(cfg_ready), 32'd1);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin : driver
    int w;
    rst       = 1'b0;
    cfg_valid = 1'b0;
    cfg_chan  = '0;
    cfg_div   = '0;
`ifdef DIVIDER_SYNC_EN
    sync_i    = 1'b0;
`endif
    repeat (3) @(negedge clk);
    cfg_chan = CW'(1);
    #1;
    chk("rst_tick",   32'(tick_o),    32'h00);
    chk("rst_level",  32'(level_o),   32'h1f);
    chk("rst_active", 32'(active_o),  32'h1f);
    chk("rst_ready",  32'(cfg_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;

    // default divide-by-4 on every channel
    wait_edge(1); chk("e1_level", 32'(level_o), 32'h1f);
    wait_edge(2); chk("e2_level", 32'(level_o), 32'h00);
    wait_edge(3); chk("e3_tick",  32'(tick_o),  32'h1f);

    // ch1 -> 5 mid-period: old period finishes, applied on edge 8
    wait_edge(4); cfg_write(1, 5, w);
    chk("ch1_busy", 32'(cfg_ready), 32'd0);
    wait_edge(7);  chk("ch1_busy_e7",  32'(cfg_ready), 32'd0);
    wait_edge(8);  chk("ch1_ready_e8", 32'(cfg_ready), 32'd1);
    wait_edge(11); chk("e11_tick", 32'(tick_o), 32'h1d);
    wait_edge(12); chk("e12_tick", 32'(tick_o), 32'h02);

    // ch2 -> 0 then -> 3
    wait_edge(13); cfg_write(2, 0, w);
    wait_edge(15); chk("e15_active", 32'(active_o), 32'h1f);
    wait_edge(16); chk("e16_active", 32'(active_o), 32'h1b);
    chk("e16_level2", 32'(level_o[2]), 32'd0);
    wait_edge(18); cfg_write(2, 3, w);
    chk("e19_active2", 32'(active_o[2]), 32'd0);
    wait_edge(20); chk("e20_active2", 32'(active_o[2]), 32'd1);
    wait_edge(21); chk("e21_tick2",   32'(tick_o[2]),   32'd0);
    wait_edge(22); chk("e22_tick2",   32'(tick_o[2]),   32'd1);

    // back-to-back writes to ch0: 6 applies at edge 28, 2 at edge 34
    wait_edge(24); cfg_write(0, 6, w);
    cfg_write(0, 2, w);
    chk("b2b_wait", 32'(w), 32'd3);
    wait_edge(31); chk("e31_tick0", 32'(tick_o[0]), 32'd0);
    wait_edge(33); chk("e33_tick0", 32'(tick_o[0]), 32'd1);
    wait_edge(34); chk("e34_tick0", 32'(tick_o[0]), 32'd0);
    wait_edge(35); chk("e35_tick0", 32'(tick_o[0]), 32'd1);

    // max divisor on ch3 (applied edge 40), out-of-range write in between
    wait_edge(36); cfg_write(3, 15, w);
    wait_edge(41); cfg_write(7, 1, w);
    chk("oor_wait",  32'(w),         32'd0);
    chk("oor_ready", 32'(cfg_ready), 32'd1);
    wait_edge(47); chk("e47_level3", 32'(level_o[3]), 32'd1);
    wait_edge(48); chk("e48_level3", 32'(level_o[3]), 32'd0);
    wait_edge(53); chk("e53_tick3",  32'(tick_o[3]),  32'd0);
    wait_edge(54); chk("e54_tick3",  32'(tick_o[3]),  32'd1);

    // reset mid-period with a pending write on ch1
    wait_edge(60); cfg_write(1, 7, w);
    rst      = 1'b0;
    cfg_chan = CW'(1);
    #1;
    chk("mid_rst_level",  32'(level_o),   32'h1f);
    chk("mid_rst_active", 32'(active_o),  32'h1f);
    chk("mid_rst_ready",  32'(cfg_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    wait_edge(3); chk("post_rst_e3_tick", 32'(tick_o), 32'h1f);

`ifdef DIVIDER_SYNC_EN
    // ch1 -> 6 held pending, then sync at edge 6 aligns everything
    wait_edge(4); cfg_write(1, 6, w);
    sync_i = 1'b1;
    @(negedge clk);
    sync_i = 1'b0;
    wait_edge(9);  chk("sync_e9_tick",  32'(tick_o), 32'h1d);
    wait_edge(11); chk("sync_e11_tick", 32'(tick_o), 32'h02);
    wait_edge(17); chk("sync_e17_tick", 32'(tick_o), 32'h1f);
`endif

    wait_edge(20);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
